conv_window_fetch: RTL and testbench
====================================

# conv_window_fetch

Window fetch stage directly downstream of the convolution anchor controller. For each anchor pair it receives, it walks the weight_length × weight_width × input_channel receptive field and issues one image-RAM read per element, with the matching weight-RAM read. It applies zero padding and streams the fetched pixels to the conv unit with first/last framing. It then holds until the conv unit reports the window result through cu_out_valid.

## Interface
Parameters:
- data_width, 16, pixel word width (float16 bit pattern) and anchor width
- addr_width, 16, image and weight RAM address width
- input_channel, 2, number of channels summed per window
- image_length, 4, image columns (anchor_1D axis)
- image_width, 4, image rows (anchor_2D axis)
- weight_length, 3, kernel columns
- weight_width, 3, kernel rows
- padding, 0, zero border on each side (0 = none)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset, synchronous, active-high
- cu_conv_en  in  1  window request from the controller, held high until the window completes
- anchor_1D  in  data_width  window top-left column in padded coordinates
- anchor_2D  in  data_width  window top-left row in padded coordinates
- cu_out_valid  in  1  conv unit has finished the current window
- img_rd_en  out  1  image RAM read strobe
- img_rd_addr  out  addr_width  image RAM address
- img_rd_data  in  data_width  image RAM data, valid 1 cycle after img_rd_en
- w_rd_en  out  1  weight RAM read strobe
- w_rd_addr  out  addr_width  weight RAM address
- pix_valid  out  1  pix_data valid this cycle
- pix_data  out  data_width  window element (16'h0000 for padding)
- pix_first  out  1  first element of the window
- pix_last  out  1  last element of the window
- busy  out  1  high in any state other than IDLE

## Operation
- N = input_channel*weight_length*weight_width elements per window.
- Element order:
  - channel c is the outer loop,
  - then kernel row r (0..weight_width-1),
  - then kernel column k (0..weight_length-1), innermost.
- Coordinates: x = anchor_1D+k, y = anchor_2D+r, using latched anchors.
- In-bounds test: padding ≤ x < image_length+padding and padding ≤ y < image_width+padding.
- img_rd_addr = c*image_length*image_width + (y-padding)*image_length + (x-padding).
  - Unsigned arithmetic, truncated to addr_width.
  - Driven 0 when the element is out of bounds.
- img_rd_en: high only for in-bounds elements during FETCH.
- w_rd_addr = c*weight_length*weight_width + r*weight_length + k.
- w_rd_en: high for every element during FETCH.
- pix_data:
  - img_rd_data if the element issued in the previous cycle was in bounds,
  - else 16'h0000.
- Anchor range is not checked; the controller guarantees anchor ≤ padded size − kernel size.
- FSM states:
  - IDLE: if cu_conv_en=1, latch both anchors, clear the c/r/k counters, go to FETCH.
  - FETCH: issue one element per cycle and advance k, then r, then c. After issuing element N-1, go to DRAIN.
  - DRAIN: emit the final pixel, then go to WAIT.
  - WAIT: hold. On cu_out_valid=1, go to IDLE.
- Back-to-back windows: the controller updates the anchors on the cu_out_valid cycle and keeps cu_conv_en high, so the next window starts from IDLE on the following cycle.
- Abort: cu_conv_en=0 in FETCH, DRAIN or WAIT means:
  - IDLE on the next cycle,
  - all strobes low from that cycle,
  - any in-flight pixel suppressed (pix_valid stays 0).
- cu_out_valid is ignored outside WAIT.

## Timing
- Reset, and the cycle after reset deassertion:
  - state IDLE, counters 0;
  - img_rd_en, w_rd_en, pix_valid, pix_first, pix_last, busy all 0;
  - img_rd_addr, w_rd_addr, pix_data all 0.
- Reset mid-window takes priority over all inputs; no pixel is emitted afterward.
- Request sampled in IDLE at cycle t:
  - issues occupy cycles t+1 .. t+N (addresses and strobes combinational from state and counters);
  - pix_valid is high in cycles t+2 .. t+N+1;
  - pix_first is high at t+2, pix_last at t+N+1 (the DRAIN cycle);
  - WAIT begins at t+N+2.
- pix_valid, pix_first, pix_last and the padding flag are registered one cycle after issue, aligned with the RAM read latency.
- Minimum window period is N+3 cycles (cu_out_valid in the first WAIT cycle, then one IDLE cycle).
- No backpressure: the consumer accepts every pix_valid beat.

## Test plan
- Defaults, anchors (0,0), cu_conv_en at cycle 0:
  - img_rd_addr sequence 0,1,2,4,5,6,8,9,10,16,17,18,20,21,22,24,25,26 in cycles 1..18;
  - w_rd_addr 0..17;
  - pix_first at cycle 2, pix_last at cycle 19, busy high from cycle 1.
- Defaults, anchors (1,1):
  - first img_rd_addr 5, last 31;
  - pix_data equals the RAM model contents in order.
- padding=1, anchors (0,0):
  - per channel, elements (r=0, any k) and (any r, k=0) read nothing: img_rd_en=0 and pix_data=16'h0000;
  - the 4 in-bounds elements read addresses 0,1,4,5 (channel 1: 16,17,20,21);
  - 18 beats total.
- Back-to-back:
  - cu_out_valid at the first WAIT cycle with new anchors (1,0);
  - one IDLE cycle, then a new FETCH starting at address 1;
  - cu_out_valid pulses during FETCH are ignored.
- Abort: drop cu_conv_en after 5 issues; busy=0 and all strobes low the next cycle, no further pix_valid.
- Reset asserted during FETCH: all outputs 0 the next cycle; a fresh request afterward restarts at element 0.

Source files
------------

// File: rtl/conv_window_fetch.sv
// Window fetch stage: walks one receptive field per anchor pair,
// issues image/weight RAM reads and streams padded pixels to the conv unit.
module conv_window_fetch #(
    parameter int data_width    = 16,
    parameter int addr_width    = 16,
    parameter int input_channel = 2,
    parameter int image_length  = 4,
    parameter int image_width   = 4,
    parameter int weight_length = 3,
    parameter int weight_width  = 3,
    parameter int padding       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cu_conv_en,
    input  logic [data_width-1:0] anchor_1D,
    input  logic [data_width-1:0] anchor_2D,
    input  logic                  cu_out_valid,
    output logic                  img_rd_en,
    output logic [addr_width-1:0] img_rd_addr,
    input  logic [data_width-1:0] img_rd_data,
    output logic                  w_rd_en,
    output logic [addr_width-1:0] w_rd_addr,
    output logic                  pix_valid,
    output logic [data_width-1:0] pix_data,
    output logic                  pix_first,
    output logic                  pix_last,
    output logic                  busy
);

    localparam int CW = input_channel > 1 ? $clog2(input_channel) : 1;
    localparam int RW = weight_width > 1 ? $clog2(weight_width) : 1;
    localparam int KW = weight_length > 1 ? $clog2(weight_length) : 1;

    localparam logic [CW-1:0] C_MAX = CW'(input_channel - 1);
    localparam logic [RW-1:0] R_MAX = RW'(weight_width - 1);
    localparam logic [KW-1:0] K_MAX = KW'(weight_length - 1);

    localparam logic [31:0] PAD    = 32'(padding);
    localparam logic [31:0] IL     = 32'(image_length);
    localparam logic [31:0] IW     = 32'(image_width);
    localparam logic [31:0] IMG_SZ = 32'(image_length * image_width);
    localparam logic [31:0] WL     = 32'(weight_length);
    localparam logic [31:0] W_SZ   = 32'(weight_length * weight_width);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         c;
    logic [RW-1:0]         r;
    logic [KW-1:0]         k;
    logic [data_width-1:0] ax;
    logic [data_width-1:0] ay;
    logic                  pv;
    logic                  pf;
    logic                  pl;
    logic                  pad_q;

    logic        fetch;
    logic        k_end;
    logic        r_end;
    logic        first_el;
    logic        last_el;
    logic        inb;
    logic [31:0] xo;
    logic [31:0] yo;

    always_comb begin
        fetch    = state == FETCH;
        k_end    = k == K_MAX;
        r_end    = r == R_MAX;
        first_el = c == '0 && r == '0 && k == '0;
        last_el  = c == C_MAX && r_end && k_end;
        // Offsets below the border wrap to huge values and fail the bound test
        xo       = 32'(ax) + 32'(k) - PAD;
        yo       = 32'(ay) + 32'(r) - PAD;
        inb      = xo < IL && yo < IW;

        img_rd_en   = fetch && inb;
        img_rd_addr = '0;
        if (img_rd_en)
            img_rd_addr = addr_width'(32'(c) * IMG_SZ + yo * IL + xo);

        w_rd_en   = fetch;
        w_rd_addr = '0;
        if (fetch)
            w_rd_addr = addr_width'(32'(c) * W_SZ + 32'(r) * WL + 32'(k));

        pix_valid = pv;
        pix_first = pf;
        pix_last  = pl;
        pix_data  = (pv && !pad_q) ? img_rd_data : '0;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            c     <= '0;
            r     <= '0;
            k     <= '0;
            ax    <= '0;
            ay    <= '0;
            pv    <= 1'b0;
            pf    <= 1'b0;
            pl    <= 1'b0;
            pad_q <= 1'b0;
        end else begin
            pv    <= 1'b0;
            pf    <= 1'b0;
            pl    <= 1'b0;
            pad_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cu_conv_en) begin
                        ax    <= anchor_1D;
                        ay    <= anchor_2D;
                        c     <= '0;
                        r     <= '0;
                        k     <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!cu_conv_en) begin
                        state <= IDLE;
                        c     <= '0;
                        r     <= '0;
                        k     <= '0;
                    end else begin
                        // Framing is delayed one cycle to line up with RAM data
                        pv    <= 1'b1;
                        pf    <= first_el;
                        pl    <= last_el;
                        pad_q <= !inb;
                        if (last_el) begin
                            c     <= '0;
                            r     <= '0;
                            k     <= '0;
                            state <= DRAIN;
                        end else if (!k_end) begin
                            k <= k + 1'b1;
                        end else begin
                            k <= '0;
                            if (!r_end) begin
                                r <= r + 1'b1;
                            end else begin
                                r <= '0;
                                c <= c + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    state <= cu_conv_en ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!cu_conv_en || cu_out_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: unpadded and padded instances,
// each backed by a RAM model returning 16'h1000 + address.
module tb_conv_window_fetch;

    localparam int N = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        sel;
    logic        cu_out_valid;
    logic [15:0] a1;
    logic [15:0] a2;

    logic        a_ire, a_wre, a_pv, a_pf, a_pl, a_busy;
    logic [15:0] a_ira, a_wra, a_pd;
    logic [15:0] a_rd = 16'h0;
    logic        b_ire, b_wre, b_pv, b_pf, b_pl, b_busy;
    logic [15:0] b_ira, b_wra, b_pd;
    logic [15:0] b_rd = 16'h0;

    logic        ire, wre, pv, pf, pl, busy;
    logic [15:0] ira, wra, pd;

    assign ire  = sel ? b_ire  : a_ire;
    assign wre  = sel ? b_wre  : a_wre;
    assign pv   = sel ? b_pv   : a_pv;
    assign pf   = sel ? b_pf   : a_pf;
    assign pl   = sel ? b_pl   : a_pl;
    assign busy = sel ? b_busy : a_busy;
    assign ira  = sel ? b_ira  : a_ira;
    assign wra  = sel ? b_wra  : a_wra;
    assign pd   = sel ? b_pd   : a_pd;

    conv_window_fetch dut_a (
        .clk(clk), .reset(reset), .cu_conv_en(en & ~sel),
        .anchor_1D(a1), .anchor_2D(a2), .cu_out_valid(cu_out_valid),
        .img_rd_en(a_ire), .img_rd_addr(a_ira), .img_rd_data(a_rd),
        .w_rd_en(a_wre), .w_rd_addr(a_wra),
        .pix_valid(a_pv), .pix_data(a_pd), .pix_first(a_pf),
        .pix_last(a_pl), .busy(a_busy)
    );

    conv_window_fetch #(.padding(1)) dut_b (
        .clk(clk), .reset(reset), .cu_conv_en(en & sel),
        .anchor_1D(a1), .anchor_2D(a2), .cu_out_valid(cu_out_valid),
        .img_rd_en(b_ire), .img_rd_addr(b_ira), .img_rd_data(b_rd),
        .w_rd_en(b_wre), .w_rd_addr(b_wra),
        .pix_valid(b_pv), .pix_data(b_pd), .pix_first(b_pf),
        .pix_last(b_pl), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (a_ire) a_rd <= 16'h1000 + a_ira;
        if (b_ire) b_rd <= 16'h1000 + b_ira;
    end

    int n_chk = 0;
    int n_fail = 0;
    int tbl[N] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                   16, 17, 18, 20, 21, 22, 24, 25, 26};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected image address for element (c,r,k), -1 when in the border
    function automatic int ea(int c, int r, int k, int ax, int ay, int pad);
        int x = ax + k;
        int y = ay + r;
        if (x < pad || x >= 4 + pad || y < pad || y >= 4 + pad) return -1;
        return c * 16 + (y - pad) * 4 + (x - pad);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ire"}, ire, 0);
        chk({tag, "_wre"}, wre, 0);
        chk({tag, "_pv"}, pv, 0);
        chk({tag, "_pf"}, pf, 0);
        chk({tag, "_pl"}, pl, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ira"}, ira, 0);
        chk({tag, "_wra"}, wra, 0);
        chk({tag, "_pd"}, pd, 0);
    endtask

    // Entered in an IDLE cycle; returns in the first WAIT cycle
    task automatic win(input int ax, input int ay, input bit use_tbl,
                       input bit glitch);
        int pad = sel ? 1 : 0;
        int e = 0;
        int prev = 0;
        a1 = 16'(ax);
        a2 = 16'(ay);
        en = 1'b1;
        for (int i = 1; i <= N + 1; i++) begin
            tick;
            if (glitch) cu_out_valid = (i == 3);
            if (i <= N) begin
                int j;
                j = i - 1;
                e = use_tbl ? tbl[j] : ea(j / 9, (j % 9) / 3, j % 3, ax, ay, pad);
                chk("busy", busy, 1);
                chk("img_en", ire, e >= 0);
                chk("img_addr", ira, e >= 0 ? e : 0);
                chk("w_en", wre, 1);
                chk("w_addr", wra, j);
            end
            if (i >= 2) begin
                chk("pix_valid", pv, 1);
                chk("pix_data", pd, prev >= 0 ? 32'h1000 + prev : 0);
                chk("pix_first", pf, i == 2);
                chk("pix_last", pl, i == N + 1);
            end
            prev = e;
        end
        tick;
        chk("wait_busy", busy, 1);
        chk("wait_pv", pv, 0);
        chk("wait_wen", wre, 0);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        sel = 1'b0;
        cu_out_valid = 1'b0;
        a1 = 16'h0;
        a2 = 16'h0;
        repeat (3) tick;
        chk_zero("in_reset");
        reset = 1'b0;
        tick;
        chk_zero("post_reset");
        chk("post_reset_b_busy", b_busy, 0);

        win(0, 0, 1'b1, 1'b0);
        cu_out_valid = 1'b1;
        a1 = 16'd1;
        a2 = 16'd0;
        tick;
        cu_out_valid = 1'b0;
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_wen", wre, 0);
        win(1, 0, 1'b0, 1'b1);
        en = 1'b0;
        tick;
        chk("wait_abort_busy", busy, 0);

        win(1, 1, 1'b0, 1'b0);
        en = 1'b0;
        tick;
        chk("a11_end_busy", busy, 0);

        sel = 1'b1;
        win(0, 0, 1'b0, 1'b0);
        en = 1'b0;
        tick;
        chk("pad_end_busy", busy, 0);
        sel = 1'b0;
        #1;

        a1 = 16'd0;
        a2 = 16'd0;
        en = 1'b1;
        repeat (5) tick;
        chk("abort_5th_addr", ira, 5);
        en = 1'b0;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_ire", ire, 0);
        chk("abort_wre", wre, 0);
        chk("abort_pv", pv, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort_no_pv", pv, 0);
        end

        en = 1'b1;
        repeat (4) tick;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick;
        chk_zero("mid_reset");
        reset = 1'b0;
        en = 1'b0;
        tick;
        chk("after_reset_pv", pv, 0);
        win(0, 1, 1'b0, 1'b0);
        en = 1'b0;
        tick;
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
